// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: 2-cycle multiply, 34-cycle restoring divide,
// 2-cycle fast path for divide-by-zero and signed overflow.
module rv32m_muldiv_unit #(
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [4:0]       ALUOP,
    input  logic [31:0]      OPERAND1,
    input  logic [31:0]      OPERAND2,
    input  logic [TAG_W-1:0] TAG_IN,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [31:0]      RESULT,
    output logic [TAG_W-1:0] TAG_OUT
);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q;
    logic [32:0]      mula_q, mulb_q;
    logic [31:0]      dvd_q, dvs_q, rem_q;
    logic [5:0]       cnt_q;
    logic             hi_q, is_rem_q, qneg_q, rneg_q, fast_q;
    logic [TAG_W-1:0] tag_q;
    logic             done_q;
    logic [31:0]      result_q;
    logic [TAG_W-1:0] tag_out_q;

    logic        is_mul, is_div, sgn_div, is_rem, s1, s2, div0, ovf;
    logic [31:0] mag1, mag2, fast_res;
    logic [63:0] prod;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        is_mul   = (ALUOP >= OP_MUL) && (ALUOP <= OP_MULHU);
        is_div   = (ALUOP >= OP_DIV) && (ALUOP <= OP_REMU);
        sgn_div  = (ALUOP == OP_DIV) || (ALUOP == OP_REM);
        is_rem   = (ALUOP == OP_REM) || (ALUOP == OP_REMU);
        s1       = sgn_div & OPERAND1[31];
        s2       = sgn_div & OPERAND2[31];
        mag1     = s1 ? -OPERAND1 : OPERAND1;
        mag2     = s2 ? -OPERAND2 : OPERAND2;
        div0     = (OPERAND2 == '0);
        ovf      = sgn_div && (OPERAND1 == 32'h8000_0000) && (OPERAND2 == '1);
        fast_res = div0 ? (is_rem ? OPERAND1 : '1) : (is_rem ? '0 : 32'h8000_0000);
        prod     = 64'($signed(mula_q) * $signed(mulb_q));
        trial    = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
        quo_fix  = qneg_q ? -dvd_q : dvd_q;
        rem_fix  = rneg_q ? -rem_q : rem_q;
    end

    // dvd_q shifts the dividend out at the top and collects quotient bits at
    // the bottom; on the fast path it holds the precomputed result instead.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            mula_q    <= '0;
            mulb_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= 1'b0;
            is_rem_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            fast_q    <= 1'b0;
            tag_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (FLUSH) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (START && is_mul) begin
                            mula_q  <= {OPERAND1[31] & (ALUOP != OP_MULHU), OPERAND1};
                            mulb_q  <= {OPERAND2[31] & ((ALUOP == OP_MUL) || (ALUOP == OP_MULH)), OPERAND2};
                            hi_q    <= (ALUOP != OP_MUL);
                            tag_q   <= TAG_IN;
                            state_q <= MUL;
                        end else if (START && is_div) begin
                            tag_q    <= TAG_IN;
                            is_rem_q <= is_rem;
                            cnt_q    <= '0;
                            rem_q    <= '0;
                            if (div0 || ovf) begin
                                fast_q  <= 1'b1;
                                dvd_q   <= fast_res;
                                state_q <= FIX;
                            end else begin
                                fast_q  <= 1'b0;
                                dvd_q   <= mag1;
                                dvs_q   <= mag2;
                                qneg_q  <= s1 ^ s2;
                                rneg_q  <= s1;
                                state_q <= DIV;
                            end
                        end
                    end
                    MUL: begin
                        result_q  <= hi_q ? prod[63:32] : prod[31:0];
                        tag_out_q <= tag_q;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                    DIV: begin
                        if (!trial[32]) rem_q <= trial[31:0];
                        else            rem_q <= {rem_q[30:0], dvd_q[31]};
                        dvd_q <= {dvd_q[30:0], ~trial[32]};
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(DIV_STEPS - 1)) state_q <= FIX;
                    end
                    FIX: begin
                        result_q  <= fast_q ? dvd_q : (is_rem_q ? rem_fix : quo_fix);
                        tag_out_q <= tag_q;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign RESULT  = result_q;
    assign TAG_OUT = tag_out_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and checks value, tag and completion cycle.
module tb_rv32m_muldiv_unit;

    logic        CLK, RESETN, START, FLUSH, BUSY, DONE;
    logic [4:0]  ALUOP, TAG_IN, TAG_OUT;
    logic [31:0] OPERAND1, OPERAND2, RESULT;

    rv32m_muldiv_unit #(.TAG_W(5), .DIV_STEPS(32)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .ALUOP(ALUOP),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .TAG_IN(TAG_IN),
        .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .TAG_OUT(TAG_OUT)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RESETN) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missing: no DONE by cycle %0d expected result %h", sb[0].due, sb[0].res);
                void'(sb.pop_front());
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE result %h tag %0d, expected none (cycle %0d)",
                             RESULT, TAG_OUT, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", RESULT, mon_e.res);
                    chk("tag", {27'd0, TAG_OUT}, {27'd0, mon_e.tag});
                    chk("done_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    // Leaves the bench at the negedge of cycle 1 relative to the START cycle.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic push, input logic [31:0] res,
                         input int lat);
        @(negedge CLK);
        ALUOP = op; OPERAND1 = a; OPERAND2 = b; TAG_IN = tag; START = 1'b1;
        if (push) sb.push_back('{res, tag, cyc + lat});
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat);
        issue(op, a, b, tag, 1'b1, res, lat);
        repeat (lat) @(negedge CLK);
    endtask

    initial begin
        RESETN = 1'b0; START = 1'b0; FLUSH = 1'b0;
        ALUOP = '0; OPERAND1 = '0; OPERAND2 = '0; TAG_IN = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_tag", {27'd0, TAG_OUT}, 32'd0);
        RESETN = 1'b1;

        run(5'b01011, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2);
        run(5'b01100, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2);
        run(5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 2);
        run(5'b01101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2);

        issue(5'b01111, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFD, 34);
        for (int i = 1; i <= 33; i++) begin
            chk("div_busy_high", {31'd0, BUSY}, 32'd1);
            @(negedge CLK);
        end
        chk("div_busy_low_at_done", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        run(5'b10001, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
        run(5'b10000, 32'd100, 32'd7, 5'd7, 32'd14, 34);
        run(5'b10010, 32'd100, 32'd7, 5'd8, 32'd2, 34);

        run(5'b10000, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2);
        run(5'b10010, 32'd5, 32'd0, 5'd10, 32'd5, 2);
        run(5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2);
        run(5'b10001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2);

        // Back-to-back: second START lands in the first DONE cycle.
        issue(5'b01011, 32'd3, 32'd4, 5'd13, 1'b1, 32'd12, 2);
        @(negedge CLK);
        ALUOP = 5'b01011; OPERAND1 = 32'd5; OPERAND2 = 32'd6; TAG_IN = 5'd14; START = 1'b1;
        sb.push_back('{32'd30, 5'd14, cyc + 2});
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);

        ALUOP = 5'b00001; OPERAND1 = 32'd9; OPERAND2 = 32'd9; TAG_IN = 5'd15; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("illegal_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        chk("illegal_done", {31'd0, DONE}, 32'd0);
        chk("illegal_result", RESULT, 32'd30);

        // Divide with an ignored START at cycle 5 and FLUSH at cycle 10.
        issue(5'b01111, 32'd100, 32'd7, 5'd16, 1'b0, 32'd0, 34);
        repeat (4) @(negedge CLK);
        ALUOP = 5'b01011; OPERAND1 = 32'd2; OPERAND2 = 32'd2; TAG_IN = 5'd17; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("flush_busy", {31'd0, BUSY}, 32'd0);
        chk("flush_result", RESULT, 32'd30);
        chk("flush_tag", {27'd0, TAG_OUT}, 32'd14);
        repeat (40) @(negedge CLK);
        chk("flush_result_held", RESULT, 32'd30);

        issue(5'b01111, 32'd100, 32'd7, 5'd18, 1'b0, 32'd0, 34);
        repeat (5) @(negedge CLK);
        #2 RESETN = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        chk("midrst_result", RESULT, 32'd0);
        chk("midrst_tag", {27'd0, TAG_OUT}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        run(5'b10000, 32'd100, 32'd7, 5'd19, 32'd14, 34);
        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
